// File: rtl/if_fetch_queue_if.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue_if
//  Purpose  : Bundles the instruction-memory read port and the IF/ID
//             valid/ready output channel of the fetch queue.
//  Revision : 1.0 - initial release
// ============================================================================
interface if_fetch_queue_if #(
    parameter int ASIZE = 16,
    parameter int ISIZE = 32
);
    // Instruction-memory read port
    logic             imem_req;
    logic [ASIZE-1:0] imem_addr;
    logic [ISIZE-1:0] imem_rdata;

    // IF/ID handshake channel
    logic             inst_valid;
    logic             inst_ready;
    logic [ISIZE-1:0] inst_out;
    logic [ASIZE-1:0] inst_pc;

    // Fetch-queue side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_out,
        output inst_pc
    );

    // Memory / IF-ID side
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_out,
        input  inst_pc
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_queue
//  Purpose  : Instruction-fetch front end. Owns the PC, issues single-word
//             reads to instruction memory (data returns the next cycle) and
//             buffers the results in a DEPTH-entry FIFO that feeds the IF/ID
//             register over a valid/ready handshake. A redirect reloads the
//             PC and flushes both the FIFO and any in-flight read.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int               ASIZE    = 16,
    parameter int               ISIZE    = 32,
    parameter int               DEPTH    = 4,
    parameter logic [ASIZE-1:0] RESET_PC = '0
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               fetch_en,
    input  wire               redirect_valid,
    input  wire [ASIZE-1:0]   redirect_pc,
    if_fetch_queue_if.master  bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_PW = $clog2(DEPTH);   // FIFO pointer width
    localparam int c_CW = c_PW + 1;        // occupancy counter width (0..DEPTH)

    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW:0]   c_DEPTH_OCC = (c_CW + 1)'(DEPTH);

    localparam logic [1:0] c_ST_BOOT = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_HOLD = 2'd2;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [ASIZE-1:0] r_pc;
    logic [ASIZE-1:0] r_req_pc;
    logic             r_inflight;
    logic [c_CW-1:0]  r_count;
    logic [c_PW-1:0]  r_rd_ptr;
    logic [c_PW-1:0]  r_wr_ptr;
    logic [ISIZE-1:0] r_mem_inst [DEPTH];
    logic [ASIZE-1:0] r_mem_pc   [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [c_CW:0] w_occupancy;
    logic          w_req;
    logic          w_push;
    logic          w_valid;
    logic          w_pop;

    // Entries already queued plus the one still coming back from memory;
    // a new read is only issued if it is guaranteed a FIFO slot.
    assign w_occupancy = {1'b0, r_count} + {{c_CW{1'b0}}, r_inflight};

    assign w_req   = (r_state == c_ST_RUN) && !redirect_valid &&
                     (w_occupancy < c_DEPTH_OCC);

    // Read data is captured the cycle after the request unless a redirect
    // in that same cycle makes it stale.
    assign w_push  = r_inflight && !redirect_valid;

    // Redirect masks the output so the flushed head is never transferred.
    assign w_valid = (r_count != '0) && !redirect_valid;
    assign w_pop   = w_valid && bus.inst_ready;

    assign bus.imem_req   = w_req;
    assign bus.imem_addr  = r_pc;
    assign bus.inst_valid = w_valid;
    assign bus.inst_out   = r_mem_inst[r_rd_ptr];
    assign bus.inst_pc    = r_mem_pc[r_rd_ptr];

    // ------------------------------------------------------------------
    // Run-control FSM: one idle BOOT cycle, then RUN/HOLD per fetch_en.
    // Redirects deliberately leave the state untouched.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_BOOT;
        end else begin
            case (r_state)
                c_ST_BOOT: r_state <= c_ST_RUN;
                c_ST_RUN:  if (!fetch_en) r_state <= c_ST_HOLD;
                c_ST_HOLD: if (fetch_en)  r_state <= c_ST_RUN;
                default:   r_state <= c_ST_BOOT;
            endcase
        end
    end

    // PC advance and in-flight tracking; redirect reloads the PC and
    // forgets the outstanding read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= RESET_PC;
            r_req_pc   <= '0;
            r_inflight <= 1'b0;
        end else if (redirect_valid) begin
            r_pc       <= redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_req;
            if (w_req) begin
                r_req_pc <= r_pc;
                r_pc     <= r_pc + ASIZE'(1);
            end
        end
    end

    // FIFO pointers and occupancy; redirect empties the queue.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_inst[i] <= '0;
                r_mem_pc[i]   <= '0;
            end
        end else if (w_push) begin
            r_mem_inst[r_wr_ptr] <= bus.imem_rdata;
            r_mem_pc[r_wr_ptr]   <= r_req_pc;
        end
    end

    // ------------------------------------------------------------------
    // Invariants: credit scheme must keep the FIFO from overfilling.
    // ------------------------------------------------------------------
    a_count_bound : assert property (@(posedge clk) disable iff (rst)
        r_count <= c_DEPTH_CNT);

    a_no_push_full : assert property (@(posedge clk) disable iff (rst)
        !(w_push && (r_count == c_DEPTH_CNT)));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_queue
//  Purpose  : Directed scoreboard bench for if_fetch_queue. Stimulus pushes
//             the PCs it expects to be accepted; a negedge monitor pops and
//             compares on every inst_valid & inst_ready transfer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_queue;

    localparam int ASIZE = 16;
    localparam int ISIZE = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             fetch_en;
    logic             redirect_valid;
    logic [ASIZE-1:0] redirect_pc;

    if_fetch_queue_if #(.ASIZE(ASIZE), .ISIZE(ISIZE)) bus ();

    if_fetch_queue #(
        .ASIZE    (ASIZE),
        .ISIZE    (ISIZE),
        .DEPTH    (4),
        .RESET_PC (16'h0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Instruction memory: returns {A5A5, addr} the cycle after a request
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= {16'hA5A5, bus.imem_addr};
    end

    logic [ASIZE-1:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every accepted instruction must match the scoreboard head
    always @(negedge clk) begin
        if (!rst && bus.inst_valid && bus.inst_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL xfer_unexpected: actual inst_pc=%h required=no transfer", bus.inst_pc);
            end else begin
                logic [ASIZE-1:0] e;
                e = exp_q.pop_front();
                check("xfer_pc", 32'(bus.inst_pc), 32'(e));
                check("xfer_data", bus.inst_out, {16'hA5A5, e});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_range(input logic [ASIZE-1:0] first, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(first + 16'(i));
    endtask

    // Holds reset two cycles; returns at the start of cycle 0 after release
    task automatic start();
        rst            = 1'b1;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.inst_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
    endtask

    task automatic end_segment(input string name);
        bus.inst_ready = 1'b0;
        check(name, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_outputs();
        check("rst_imem_req", 32'(bus.imem_req), 32'd0);
        check("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check("rst_inst_out", bus.inst_out, 32'd0);
        check("rst_inst_pc", 32'(bus.inst_pc), 32'd0);
    endtask

    initial begin
        // ---- Tests 1 & 2: startup latency, streaming, backpressure ----
        start();
        push_range(16'h0000, 18);
        for (int c = 0; c <= 30; c++) begin
            bus.inst_ready = (c < 13) || (c >= 23);
            #1;
            if (c == 0) check_reset_outputs();
            if (c < 3) check("t1_no_early_valid", 32'(bus.inst_valid), 32'd0);
            if (c == 1) check("t1_first_req_addr", {31'(bus.imem_addr), bus.imem_req}, 32'h0000_0001);
            if (c == 3) begin
                check("t1_first_valid", 32'(bus.inst_valid), 32'd1);
                check("t1_first_pc", 32'(bus.inst_pc), 32'h0000);
            end
            if (c == 15) check("t2_req_stop_full", 32'(bus.imem_req), 32'd0);
            if (c == 20) begin
                check("t2_req_while_full", 32'(bus.imem_req), 32'd0);
                check("t2_valid_while_full", 32'(bus.inst_valid), 32'd1);
                check("t2_head_while_full", 32'(bus.inst_pc), 32'h000A);
            end
            step();
        end
        end_segment("t12_drained");

        // ---- Test 3: redirect with 5,6,7 queued and 8 in flight ----
        start();
        push_range(16'h0000, 5);
        push_range(16'h0040, 8);
        for (int c = 0; c <= 20; c++) begin
            bus.inst_ready = (c < 8) || (c >= 11);
            redirect_valid = (c == 10);
            redirect_pc    = 16'h0040;
            #1;
            if (c == 9) check("t3_head_before_redirect", 32'(bus.inst_pc), 32'h0005);
            if (c == 10) begin
                check("t3_req_in_redirect", 32'(bus.imem_req), 32'd0);
                check("t3_valid_in_redirect", 32'(bus.inst_valid), 32'd0);
            end
            if (c == 11) begin
                check("t3_req_after_redirect", {31'(bus.imem_addr), bus.imem_req}, {31'h0040, 1'b1});
                check("t3_valid_r1", 32'(bus.inst_valid), 32'd0);
            end
            if (c == 12) check("t3_valid_r2", 32'(bus.inst_valid), 32'd0);
            if (c == 13) check("t3_pc_r3", {31'(bus.inst_pc), bus.inst_valid}, {31'h0040, 1'b1});
            step();
        end
        end_segment("t3_drained");

        // ---- Test 4: redirect with full FIFO and ready high; back-to-back ----
        start();
        push_range(16'h0020, 6);
        for (int c = 0; c <= 15; c++) begin
            bus.inst_ready = (c >= 6);
            redirect_valid = (c == 6) || (c == 7);
            redirect_pc    = (c == 6) ? 16'h0030 : 16'h0020;
            #1;
            if (c == 5) check("t4_full_head", {31'(bus.inst_pc), bus.inst_valid}, {31'h0000, 1'b1});
            if (c == 6) begin
                check("t4_no_xfer_valid", 32'(bus.inst_valid), 32'd0);
                check("t4_no_req", 32'(bus.imem_req), 32'd0);
            end
            if (c == 7) check("t4_second_redirect_valid", 32'(bus.inst_valid), 32'd0);
            if (c == 8) check("t4_last_redirect_wins", {31'(bus.imem_addr), bus.imem_req}, {31'h0020, 1'b1});
            if (c == 9) check("t4_count_zero", 32'(bus.inst_valid), 32'd0);
            if (c == 10) check("t4_first_valid", {31'(bus.inst_pc), bus.inst_valid}, {31'h0020, 1'b1});
            step();
        end
        end_segment("t4_drained");

        // ---- Test 5: fetch_en low at PC 0x10, drain, resume ----
        start();
        push_range(16'h0000, 22);
        for (int c = 0; c <= 32; c++) begin
            bus.inst_ready = 1'b1;
            fetch_en       = !((c >= 17) && (c < 25));
            #1;
            if (c == 17) check("t5_last_req", {31'(bus.imem_addr), bus.imem_req}, {31'h0010, 1'b1});
            if (c == 18) check("t5_req_stopped", 32'(bus.imem_req), 32'd0);
            if (c == 22) check("t5_drained_empty", {31'(bus.imem_req), bus.inst_valid}, 32'd0);
            if (c == 25) check("t5_hold_no_req", 32'(bus.imem_req), 32'd0);
            if (c == 26) check("t5_resume_addr", {31'(bus.imem_addr), bus.imem_req}, {31'h0011, 1'b1});
            if (c == 28) check("t5_resume_pc", {31'(bus.inst_pc), bus.inst_valid}, {31'h0011, 1'b1});
            step();
        end
        end_segment("t5_drained");

        // ---- Test 6: PC wrap after redirect, then mid-stream reset ----
        start();
        exp_q.push_back(16'hFFFE);
        exp_q.push_back(16'hFFFF);
        push_range(16'h0000, 5);
        for (int c = 0; c <= 10; c++) begin
            bus.inst_ready = 1'b1;
            redirect_valid = (c == 1);
            redirect_pc    = 16'hFFFE;
            #1;
            if (c == 1) check("t6_redirect_idle", {31'(bus.imem_req), bus.inst_valid}, 32'd0);
            if (c == 2) check("t6_req_fffe", {31'(bus.imem_addr), bus.imem_req}, {31'hFFFE, 1'b1});
            if (c == 4) check("t6_pc_fffe", {31'(bus.inst_pc), bus.inst_valid}, {31'hFFFE, 1'b1});
            if (c == 6) check("t6_pc_wrap", {31'(bus.inst_pc), bus.inst_valid}, {31'h0000, 1'b1});
            step();
        end
        rst            = 1'b1;
        bus.inst_ready = 1'b0;
        redirect_valid = 1'b0;
        step();
        rst = 1'b0;
        check("t6_pre_reset_drained", 32'(exp_q.size()), 32'd0);
        push_range(16'h0000, 6);
        for (int c = 0; c <= 8; c++) begin
            bus.inst_ready = 1'b1;
            #1;
            if (c == 0) check_reset_outputs();
            if (c == 3) check("t6_restart_pc", {31'(bus.inst_pc), bus.inst_valid}, {31'h0000, 1'b1});
            step();
        end
        end_segment("t6_drained");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
